// File: rtl/moore_sched.sv
// Round-robin owner of one serial zero-run Moore detector shared by NREQ requesters.
// Latency: grant one cycle after arbitration, done pulse FRAME_W+2 cycles after it.
// Backpressure: level requests wait in IDLE. A grant is held until the frame has been shifted.
module moore_sched #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 3,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*FRAME_W-1:0]   frame,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      det_i,
  output logic                      det_y,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          hits
);

  localparam int BC_W = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  state_t             state, state_nxt;
  det_t               det_q, det_nxt;
  logic [FRAME_W-1:0] sh;
  logic [BC_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic               arb_found;
  logic [ID_W-1:0]    arb_idx;
  logic               last_bit;

  assign last_bit = (bit_cnt == BC_W'(FRAME_W - 1));

  // Round-robin search: first set request starting at ptr, wrapping modulo NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && req[(int'(ptr) + i) % NREQ]) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'((int'(ptr) + i) % NREQ);
      end
    end
  end

  // Detector transition for the bit currently at the shift register MSB.
  always_comb begin
    det_nxt = S0;
    if (!sh[FRAME_W-1]) begin
      case (det_q)
        S0:      det_nxt = S1;
        S1:      det_nxt = S2;
        S2:      det_nxt = S3;
        default: det_nxt = S1;
      endcase
    end
  end

  // Controller state register; reset aborts any service immediately.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Controller next state: arbitrate only in IDLE, fixed-length service otherwise.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_found) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: winner capture, frame load, detector stepping, hit count, pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_q   <= S0;
      sh      <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      ptr     <= '0;
      winner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) winner <= arb_idx;
        end
        LOAD: begin
          sh      <= frame[int'(winner)*FRAME_W +: FRAME_W];
          det_q   <= S0;
          cnt     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          det_q   <= det_nxt;
          sh      <= {sh[FRAME_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          // Saturate rather than wrap so a long zero frame never reports a small count.
          if (det_nxt == S3 && cnt != '1) cnt <= cnt + 1'b1;
        end
        REPORT: begin
          // The served requester drops to lowest priority for the next arbitration.
          ptr <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from controller and detector state.
  always_comb begin
    gnt     = '0;
    busy    = 1'b0;
    det_i   = 1'b0;
    done    = 1'b0;
    done_id = '0;
    hits    = '0;
    det_y   = (det_q == S3);
    case (state)
      LOAD: begin
        gnt  = NREQ'(1) << winner;
        busy = 1'b1;
      end
      SHIFT: begin
        gnt   = NREQ'(1) << winner;
        busy  = 1'b1;
        det_i = sh[FRAME_W-1];
      end
      REPORT: begin
        // Grant and busy are already released in the completion cycle.
        done    = 1'b1;
        done_id = winner;
        hits    = cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_moore_sched.sv
// Directed bench for moore_sched: a default-size instance and a saturation instance.
// Expected (id, hits) pairs are queued when a request is driven and popped on done.
// Timing, grant, detector input/output are checked cycle by cycle from a bench model.
module tb_moore_sched;
  localparam int FW  = 8;
  localparam int FWW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_done = 0;
  int prev_done = 0;

  logic [7:0] fr [4];
  logic [4:0] q [$];

  // Default instance
  logic [3:0]    req;
  logic [31:0]   frame;
  logic [3:0]    gnt;
  logic          busy, det_i, det_y, done;
  logic [1:0]    done_id;
  logic [2:0]    hits;

  // Wide-frame, narrow-counter instance
  logic [3:0]    req_w;
  logic [47:0]   frame_w;
  logic [3:0]    gnt_w;
  logic          busy_w, det_i_w, det_y_w, done_w;
  logic [1:0]    done_id_w;
  logic [1:0]    hits_w;

  moore_sched #(.NREQ(4), .FRAME_W(FW), .CNT_W(3), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .gnt(gnt), .busy(busy),
    .det_i(det_i), .det_y(det_y), .done(done), .done_id(done_id), .hits(hits)
  );

  moore_sched #(.NREQ(4), .FRAME_W(FWW), .CNT_W(2), .ID_W(2)) dut_w (
    .clk(clk), .rst(rst), .req(req_w), .frame(frame_w), .gnt(gnt_w), .busy(busy_w),
    .det_i(det_i_w), .det_y(det_y_w), .done(done_w), .done_id(done_id_w), .hits(hits_w)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse of the default instance must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_done: got done=1 id=%0d hits=%0d expected no done", done_id, hits);
      end
      if (q.size() != 0) begin
        logic [4:0] e;
        e = q.pop_front();
        tests++;
        assert ({done_id, hits} === e) else begin
          fails++;
          $error("FAIL done_result: got id=%0d hits=%0d expected id=%0d hits=%0d",
                 done_id, hits, e[4:3], e[2:0]);
        end
      end
    end
  end

  // Called at the negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
  // mode 0: drop req in the done cycle, 1: keep req, 2: drop req right after the grant.
  task automatic serve(input logic [3:0] r, input int id, input int exp_hits, input int mode);
    logic [7:0] f;
    logic       b;
    int         m;
    f = fr[id];
    m = 0;
    q.push_back({2'(id), 3'(exp_hits)});
    req = r;
    for (int k = 1; k <= FW + 2; k++) begin
      @(negedge clk);
      if (k <= FW + 1) begin
        chk("gnt", {28'd0, gnt}, 32'(1 << id));
        chk("busy", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
      end
      if (k >= 2) chk("det_y", {31'd0, det_y}, {31'd0, (m == 3)});
      if (k >= 2 && k <= FW + 1) begin
        b = f[FW - 1 - (k - 2)];
        chk("det_i", {31'd0, det_i}, {31'd0, b});
        m = b ? 0 : ((m == 3) ? 1 : m + 1);
      end
      if (k == FW + 2) begin
        chk("done", {31'd0, done}, 32'd1);
        chk("gnt_report", {28'd0, gnt}, 32'd0);
        chk("busy_report", {31'd0, busy}, 32'd0);
        chk("det_i_report", {31'd0, det_i}, 32'd0);
        last_done = cyc;
        if (mode == 0) req = 4'b0000;
      end
      if (mode == 2 && k == 2) req = 4'b0000;
    end
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int hv [4];
    int kd;
    fr[0] = 8'h00;
    fr[1] = 8'b0001_0000;
    fr[2] = 8'hFF;
    fr[3] = 8'b0100_1000;
    hv[0] = 2; hv[1] = 2; hv[2] = 0; hv[3] = 1;
    frame   = {fr[3], fr[2], fr[1], fr[0]};
    frame_w = '0;
    req     = 4'b0000;
    req_w   = 4'b0000;
    rst     = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_det_i", {31'd0, det_i}, 32'd0);
    chk("rst_det_y", {31'd0, det_y}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_done_id", {30'd0, done_id}, 32'd0);
    chk("rst_hits", {29'd0, hits}, 32'd0);
    chk("rst_busy_w", {31'd0, busy_w}, 32'd0);
    rst = 1'b0;

    // Single requesters, one per frame pattern; requester 1 drops req mid-service
    serve(4'b0001, 0, 2, 0);
    serve(4'b0010, 1, 2, 2);
    serve(4'b0100, 2, 0, 0);
    serve(4'b1000, 3, 1, 0);

    // All requesting continuously: order 0,1,2,3,0 with 11-cycle done spacing
    for (int j = 0; j < 5; j++) begin
      prev_done = last_done;
      serve(4'b1111, j % 4, hv[j % 4], (j == 4) ? 0 : 1);
      if (j > 0) chk("done_spacing", 32'(last_done - prev_done), 32'd11);
    end

    // Reset during SHIFT of requester 2 (pointer is at 1 here, only req[2] set)
    req = 4'b0100;
    repeat (4) @(negedge clk);
    chk("pre_rst_gnt", {28'd0, gnt}, 32'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_det_i", {31'd0, det_i}, 32'd0);
    chk("mid_rst_det_y", {31'd0, det_y}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_done_id", {30'd0, done_id}, 32'd0);
    chk("mid_rst_hits", {29'd0, hits}, 32'd0);
    rst = 1'b0;
    req = 4'b0000;
    repeat (14) @(negedge clk);
    serve(4'b1111, 0, 2, 0);

    // Wide frame of zeros: four detections saturate a 2-bit counter at 3
    req_w = 4'b0001;
    kd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (kd == 0 && done_w === 1'b1) begin
        kd = k;
        chk("wide_done_id", {30'd0, done_id_w}, 32'd0);
        chk("wide_hits", {30'd0, hits_w}, 32'd3);
        req_w = 4'b0000;
      end
    end
    chk("wide_done_cycle", 32'(kd), 32'(FWW + 2));

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
